// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone memory slave.
package wb_pkg;
    localparam int DATA_W = 16;
    localparam int ADR_W  = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    function automatic logic adr_ok(input logic [ADR_W-1:0] adr, input int depth);
        return (32'(adr) < 32'(depth));
    endfunction
endpackage

// File: rtl/wb_slave_ram.sv
// Word storage with two byte-lane write enables and a registered read port.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic [1:0]        i_we,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
        if (i_we[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
        if (i_rd_en) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone slave: request capture, wait-state counter and termination FSM
// in front of a byte-lane RAM.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_in,
    input  logic              stb_in,
    input  logic              we_in,
    input  logic [ADR_W-1:0]  adr_in,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              akn_out,
    output logic              err_out
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADR_W-1:0]  r_adr;
    logic [1:0]        r_sel;
    logic [DATA_W-1:0] r_wdata;

    logic              w_cap, w_go_ack, w_idle, w_we_req, w_ok, w_ram_rd;
    logic [ADR_W-1:0]  w_adr;
    logic [1:0]        w_sel, w_ram_we;
    logic [DATA_W-1:0] w_wdata, w_rdata;
    logic              w_unused_sel;

    assign w_unused_sel = ^sel_in[3:2];

    assign w_idle = (r_state == IDLE);
    assign w_cap  = w_idle && cyc_in && stb_in;
    // The RAM is accessed on the edge entering ACK; with zero wait states
    // that is the capture edge itself, so the request comes straight from the bus.
    assign w_go_ack = rst && (((r_state == WAIT) && (r_cnt == 4'd1) && cyc_in)
                              || (w_cap && (WAIT_STATES == 0)));
    assign w_adr    = w_idle ? adr_in       : r_adr;
    assign w_we_req = w_idle ? we_in        : r_we;
    assign w_sel    = w_idle ? sel_in[1:0]  : r_sel;
    assign w_wdata  = w_idle ? data_in      : r_wdata;
    assign w_ok     = adr_ok(w_adr, MEM_DEPTH);
    assign w_ram_we = {2{w_go_ack && w_we_req && w_ok}} & w_sel;
    assign w_ram_rd = w_go_ack && !w_we_req;

    wb_slave_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_rd_en (w_ram_rd),
        .i_addr  (w_adr[AW-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_sel    <= '0;
            r_wdata  <= '0;
            akn_out  <= 1'b0;
            err_out  <= 1'b0;
            data_out <= '0;
        end else begin
            akn_out <= 1'b0;
            err_out <= 1'b0;
            case (r_state)
                IDLE: if (w_cap) begin
                    r_adr   <= adr_in;
                    r_we    <= we_in;
                    r_sel   <= sel_in[1:0];
                    r_wdata <= data_in;
                    r_cnt   <= 4'(WAIT_STATES);
                    r_state <= (WAIT_STATES == 0) ? ACK : WAIT;
                end
                WAIT: begin
                    if (!cyc_in) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    if (adr_ok(r_adr, MEM_DEPTH)) begin
                        akn_out  <= 1'b1;
                        data_out <= r_we ? '0 : w_rdata;
                    end else begin
                        err_out  <= 1'b1;
                        data_out <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench: three slaves (1, 3 and 0 wait states) on one clock,
// terminations checked against a per-slave scoreboard queue.
`timescale 1ns/1ps
module tb_wb_mem_slave;
    import wb_pkg::*;

    localparam int N = 3;
    localparam logic [2:0][3:0] WS_PK = {4'd0, 4'd3, 4'd1};

    typedef struct {
        logic        err;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        bit          we;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic [15:0] wdata;
        bit          exp_err;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc [N];
    logic        stb [N];
    logic        we  [N];
    logic [15:0] adr [N];
    logic [3:0]  sel [N];
    logic [15:0] din [N];
    logic [15:0] dout[N];
    logic        akn [N];
    logic        err [N];

    exp_t q [N][$];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_mem_slave #(.MEM_DEPTH(1024), .WAIT_STATES(int'(WS_PK[g]))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .cyc_in   (cyc[g]),
            .stb_in   (stb[g]),
            .we_in    (we[g]),
            .adr_in   (adr[g]),
            .sel_in   (sel[g]),
            .data_in  (din[g]),
            .data_out (dout[g]),
            .akn_out  (akn[g]),
            .err_out  (err[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int ws(input int k);
        return int'(WS_PK[k]);
    endfunction

    function automatic vec_t mk(input bit w, input logic [15:0] a, input logic [1:0] s,
                                input logic [15:0] d, input bit e, input logic [15:0] x);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.wdata = d; v.exp_err = e; v.exp_data = x;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every termination pops the oldest expectation for that slave.
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (akn[k] === 1'b1 || err[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_term dut%0d: akn %b err %b, none expected", k, akn[k], err[k]);
                end else begin
                    e = q[k].pop_front();
                    check($sformatf("term_err dut%0d", k), 32'(err[k]), 32'(e.err));
                    check($sformatf("term_akn dut%0d", k), 32'(akn[k]), 32'(!e.err));
                    check($sformatf("term_data dut%0d", k), 32'(dout[k]), 32'(e.data));
                end
            end
        end
    end

    task automatic xfer(input int k, input bit w, input logic [15:0] a, input logic [1:0] s,
                        input logic [15:0] d, input bit exp_err, input logic [15:0] exp_data);
        exp_t e;
        int   n;
        bit   done;
        @(negedge clk);
        e.err = exp_err; e.data = exp_data;
        q[k].push_back(e);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; din[k] = d;
        sel[k] = {2'($urandom_range(3, 0)), s};
        @(posedge clk);
        @(negedge clk);
        // Scramble everything but cyc: only the captured request may matter now.
        stb[k] = 1'b0; we[k] = ~w; adr[k] = ~a; din[k] = ~d; sel[k] = ~sel[k];
        n = 0; done = 0;
        while (!done && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (akn[k] === 1'b1 || err[k] === 1'b1) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout dut%0d adr %h: no termination in %0d cycles", k, a, n);
        end else begin
            check($sformatf("latency dut%0d adr %h", k, a), 32'(n), 32'(ws(k) + 1));
        end
        cyc[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic abort_xfer(input int k, input logic [15:0] a, input logic [15:0] d,
                              input int drop_edges);
        int seen;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = a; sel[k] = 4'h3; din[k] = d;
        @(posedge clk);
        @(negedge clk);
        stb[k] = 1'b0;
        repeat (drop_edges) begin
            @(posedge clk);
            @(negedge clk);
        end
        cyc[k] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (akn[k] === 1'b1 || err[k] === 1'b1) seen++;
        end
        check($sformatf("abort_no_term dut%0d drop%0d", k, drop_edges), 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl [17];
        int   pulses, consec, seen;
        bit   prev;

        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0; sel[k] = '0; din[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_akn dut%0d", k), 32'(akn[k]), 32'd0);
            check($sformatf("reset_err dut%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("reset_dout dut%0d", k), 32'(dout[k]), 32'd0);
        end
        rst = 1'b1;

        // Main function, 1 wait state.
        tbl[0]  = mk(1, 16'h0010, 2'b11, 16'hBEEF, 0, 16'h0000);
        tbl[1]  = mk(0, 16'h0010, 2'b00, 16'h0000, 0, 16'hBEEF);
        tbl[2]  = mk(1, 16'h0020, 2'b11, 16'hFFFF, 0, 16'h0000);
        tbl[3]  = mk(1, 16'h0020, 2'b01, 16'h1234, 0, 16'h0000);
        tbl[4]  = mk(0, 16'h0020, 2'b00, 16'h0000, 0, 16'hFF34);
        tbl[5]  = mk(1, 16'h0020, 2'b10, 16'hAB00, 0, 16'h0000);
        tbl[6]  = mk(0, 16'h0020, 2'b00, 16'h0000, 0, 16'hAB34);
        tbl[7]  = mk(1, 16'h0020, 2'b00, 16'h9999, 0, 16'h0000);
        tbl[8]  = mk(0, 16'h0020, 2'b00, 16'h0000, 0, 16'hAB34);
        tbl[9]  = mk(1, 16'h0000, 2'b11, 16'h0101, 0, 16'h0000);
        tbl[10] = mk(0, 16'h0000, 2'b00, 16'h0000, 0, 16'h0101);
        tbl[11] = mk(0, 16'h0400, 2'b00, 16'h0000, 1, 16'h0000);
        tbl[12] = mk(1, 16'h0400, 2'b11, 16'hDEAD, 1, 16'h0000);
        tbl[13] = mk(0, 16'h0000, 2'b00, 16'h0000, 0, 16'h0101);
        tbl[14] = mk(1, 16'h03FF, 2'b11, 16'h7E7E, 0, 16'h0000);
        tbl[15] = mk(0, 16'h03FF, 2'b00, 16'h0000, 0, 16'h7E7E);
        tbl[16] = mk(0, 16'hFFFF, 2'b00, 16'h0000, 1, 16'h0000);
        for (int i = 0; i < 17; i++)
            xfer(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_data);

        xfer(0, 0, 16'h0010, 2'b00, 16'h0000, 0, 16'hBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("dout_hold dut0", 32'(dout[0]), 32'h0000BEEF);

        // Aborts with 3 wait states: second WAIT cycle, then the edge entering ACK.
        xfer(1, 1, 16'h0030, 2'b11, 16'h1111, 0, 16'h0000);
        abort_xfer(1, 16'h0030, 16'h5555, 1);
        abort_xfer(1, 16'h0030, 16'h6666, 2);
        xfer(1, 0, 16'h0030, 2'b00, 16'h0000, 0, 16'h1111);

        // Reset in the middle of a pending write.
        xfer(1, 1, 16'h0040, 2'b11, 16'h2222, 0, 16'h0000);
        xfer(1, 0, 16'h0040, 2'b00, 16'h0000, 0, 16'h2222);
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 16'h0040; sel[1] = 4'h3; din[1] = 16'h3333;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_async_dout dut1", 32'(dout[1]), 32'd0);
        check("rst_async_akn dut1", 32'(akn[1]), 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (akn[1] === 1'b1 || err[1] === 1'b1) seen++;
        end
        rst = 1'b1; cyc[1] = 0; stb[1] = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (akn[1] === 1'b1 || err[1] === 1'b1) seen++;
        end
        check("rst_no_term dut1", 32'(seen), 32'd0);
        xfer(1, 0, 16'h0040, 2'b00, 16'h0000, 0, 16'h2222);

        // Zero wait states with the bus held busy: acks every other cycle.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.err = 1'b0; e.data = 16'h0000;
            q[2].push_back(e);
        end
        cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 16'h0005; sel[2] = 4'h3; din[2] = 16'h00AA;
        pulses = 0; consec = 0; prev = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (akn[2] === 1'b1) begin
                pulses++;
                if (prev) consec++;
            end
            prev = (akn[2] === 1'b1);
        end
        cyc[2] = 0; stb[2] = 0; we[2] = 0;
        check("stream_pulses dut2", 32'(pulses), 32'd6);
        check("stream_consecutive dut2", 32'(consec), 32'd0);
        xfer(2, 0, 16'h0005, 2'b00, 16'h0000, 0, 16'h00AA);

        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++)
            check($sformatf("sb_empty dut%0d", k), 32'(q[k].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
